entrada_pulsos: RTL

Input-conditioning stage placed directly upstream of the one-hot 4→2 encoder in the accumulator design. It takes the four raw board pushbuttons and performs synchronisation, per-button debounce and press arbitration. It emits exactly one single-cycle one-hot pulse per accepted press on `pulse_out`, which drives the encoder's 4-bit `A` input. Between pulses `pulse_out` is 4'b0000, so the accumulator adds nothing.

---
 rtl/entrada_pulsos_pkg.sv | 22 ++
 rtl/debounce_bit.sv | 43 ++++
 rtl/entrada_pulsos.sv | 107 ++++++++++
 3 files changed

// File: rtl/entrada_pulsos_pkg.sv
// Shared definitions for the pushbutton conditioning stage: button count,
// arbitration FSM states and the lowest-set-bit one-hot helper.
package entrada_pulsos_pkg;

    localparam int N_BTN = 4;

    typedef enum logic [1:0] {IDLE, FIRE, HOLD} ep_state_t;

    // Lower index wins when several debounced buttons are high together
    function automatic logic [N_BTN-1:0] lowestOneHot(input logic [N_BTN-1:0] v);
        logic [N_BTN-1:0] r;
        r = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One pushbutton: two-flop synchroniser followed by a stable-level filter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic inrst,
    input  logic d,
    output logic q
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Any agreeing cycle restarts the count, so short glitches never get through
    always_ff @(posedge clk or negedge inrst) begin
        if (!inrst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign q = r_level;

endmodule

// File: rtl/entrada_pulsos.sv
// Pushbutton front end: per-button debounce, lowest-index arbitration and a
// single-cycle one-hot pulse per press. Define ENTRADA_PULSOS_REPEAT_EN for auto-repeat.
module entrada_pulsos
    import entrada_pulsos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic             clk,
    input  logic             inrst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] pulse_out,
    output logic [N_BTN-1:0] btn_level,
    output logic             busy
);

    logic [N_BTN-1:0] w_level;
    ep_state_t        r_state;
    ep_state_t        w_stateNext;
    logic [N_BTN-1:0] r_sel;
    logic [N_BTN-1:0] w_selNext;

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .inrst(inrst),
            .d    (btn_in[i]),
            .q    (w_level[i])
        );
    end

`ifdef ENTRADA_PULSOS_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rptCnt;
    logic          w_selHeld;

    assign w_selHeld = |(w_level & r_sel);

    // Counts only while parked in HOLD with the chosen button still down
    always_ff @(posedge clk or negedge inrst) begin
        if (!inrst) begin
            r_rptCnt <= '0;
        end else if (r_state != HOLD || !w_selHeld || r_rptCnt == RPT_LAST) begin
            r_rptCnt <= '0;
        end else begin
            r_rptCnt <= r_rptCnt + 1'b1;
        end
    end
`else
    logic w_unusedRepeat;
    assign w_unusedRepeat = (REPEAT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge inrst) begin
        if (!inrst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_sel   <= w_selNext;
        end
    end

    // A new press is only accepted once every button has been released
    always_comb begin
        w_stateNext = r_state;
        w_selNext   = r_sel;
        case (r_state)
            IDLE: begin
                if (w_level != '0) begin
                    w_selNext   = lowestOneHot(w_level);
                    w_stateNext = FIRE;
                end
            end
            FIRE: begin
                w_stateNext = HOLD;
            end
            HOLD: begin
                if (w_level == '0) begin
                    w_stateNext = IDLE;
`ifdef ENTRADA_PULSOS_REPEAT_EN
                end else if (w_selHeld && r_rptCnt == RPT_LAST) begin
                    w_stateNext = FIRE;
`endif
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        pulse_out = '0;
        busy      = (r_state != IDLE);
        if (r_state == FIRE) begin
            pulse_out = r_sel;
        end
    end

    assign btn_level = w_level;

endmodule
